irq_sched: RTL

Interrupt scheduler between the interrupt sources (timer IRQ0, timer IRQ1, external `interrupt` pin, spare lines) and the CP0 exception logic of the pipelined MIPS core. Samples and latches requests, applies a software mask, picks one winner by fixed priority, and hands it to CP0 through a request/acknowledge handshake. It blocks further requests until the handler executes `eret`. Software reaches it as a bridge-mapped peripheral with three word registers.

---
 rtl/irq_sched.sv | 134 +++++++++++++
 1 files changed

// File: rtl/irq_sched.sv
// Interrupt scheduler: latches level/edge requests, masks them, picks a fixed-priority winner
// and hands it to CP0 through an int_req/int_ack handshake, blocking new requests until eret.
module irq_sched #(
  parameter int                NSRC     = 6,
  parameter logic [NSRC-1:0]   EDGE_SEL = 6'b000100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [NSRC-1:0] hwint,
  output logic            int_req,
  output logic [2:0]      int_id,
  input  logic            int_ack,
  input  logic            eret
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          st, st_nxt;
  logic [NSRC-1:0] pend, pend_nxt;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] hist;
  logic [7:0]      pm8;
  logic [2:0]      win_id, id_nxt;
  logic            any_pm;
  logic            ack_take;
  logic            unused_wdata;

  assign unused_wdata = ^wdata[31:NSRC];
  assign hwint        = pend & mask;
  assign ack_take     = (st == REQ) && int_ack;

  always_comb begin
    pm8             = '0;
    pm8[NSRC-1:0]   = hwint;
    any_pm          = |pm8;
    win_id          = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pm8[i]) win_id = 3'(i);
    end
  end

  // Edge bits: a fresh rising edge beats any clear arriving in the same cycle.
  always_comb begin
    pend_nxt = pend;
    for (int i = 0; i < NSRC; i++) begin
      if (EDGE_SEL[i]) begin
        pend_nxt[i] = (pend[i] & ~((we && addr == 2'd0 && wdata[i]) ||
                                   (ack_take && int_id == 3'(i))))
                    | (irq_in[i] & ~hist[i]);
      end else begin
        pend_nxt[i] = irq_in[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
      hist <= '0;
      mask <= '0;
    end else begin
      pend <= pend_nxt;
      hist <= irq_in;
      if (we && addr == 2'd1) mask <= wdata[NSRC-1:0];
    end
  end

  always_comb begin
    st_nxt = st;
    id_nxt = int_id;
    case (st)
      IDLE: begin
        if (any_pm) begin
          st_nxt = REQ;
          id_nxt = win_id;
        end else begin
          id_nxt = '0;
        end
      end
      REQ: begin
        if (int_ack) begin
          st_nxt = SERVICE;
        end else if (!pm8[int_id]) begin
          st_nxt = IDLE;
          id_nxt = '0;
        end else begin
          id_nxt = win_id;
        end
      end
      SERVICE: begin
        if (eret) begin
          st_nxt = IDLE;
          id_nxt = '0;
        end
      end
      default: begin
        st_nxt = IDLE;
        id_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= IDLE;
      int_id  <= '0;
      int_req <= 1'b0;
    end else begin
      st      <= st_nxt;
      int_id  <= id_nxt;
      int_req <= (st_nxt == REQ);
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata[NSRC-1:0] = pend;
      2'd1:    rdata[NSRC-1:0] = mask;
      2'd2:    rdata[4:0]      = {int_id, st};
      default: rdata           = '0;
    endcase
  end

endmodule
